uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  FIFO-draining UART transmitter; reader-side counterpart of the push/pop FIFO.
//  Pops words from a first-word-fall-through FIFO (rdata valid whenever !empty).
//  Serialises each word as an asynchronous frame on txd: start, data LSB-first, optional parity, 1/2 stop.
//  Sits between the peripheral TX FIFO and the pad; config comes from the UART CSR block.
// PARAMETERS
//  WIDTH      8   data bits per frame, legal 5..8; equals the attached FIFO WIDTH
//  DIV_WIDTH  16  width of the baud divisor
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          reset, asynchronous, active-low
//  en          in   1          transmitter enable; gates the start of new frames only
//  baud_div    in   DIV_WIDTH  bit period = baud_div+1 clk cycles
//  parity_en   in   1          1: insert parity bit after data
//  parity_odd  in   1          0: even parity, 1: odd parity
//  stop2       in   1          0: one stop bit, 1: two stop bits
//  fifo_empty  in   1          FIFO empty flag
//  fifo_rdata  in   WIDTH      FIFO head word, valid while !fifo_empty
//  fifo_pop    out  1          one-cycle pop strobe to FIFO
//  txd         out  1          serial output, idle high
//  busy        out  1          frame in progress
//  tx_done     out  1          one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  - Reset values: txd=1, fifo_pop=0, busy=0, tx_done=0, state IDLE, counters 0.
//  - Reset asserted mid-frame: txd goes to 1 asynchronously; frame aborted; no pop.
//  - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//  - IDLE: if en && !fifo_empty: fifo_pop=1 for that cycle, load fifo_rdata into shift reg.
//    Latch baud_div/parity_en/parity_odd/stop2 in the same cycle; go START.
//  - Latency: pop in cycle N, txd=0 from cycle N+1. en=0 or fifo_empty: no pop, txd=1.
//  - Each bit held exactly baud_div+1 cycles (baud_div=0 -> 1 cycle/bit); down-counter reloads per bit.
//  - DATA: WIDTH bits, LSB first; bit counter $clog2(WIDTH) bits; parity = XOR of data ^ parity_odd.
//  - STOP: txd=1 for 1 or 2 bit periods. In last cycle of last stop bit: tx_done=1.
//    Same cycle, if en && !fifo_empty: pop + load, next cycle START (no idle gap); else IDLE.
//  - busy=1 from START entry through last stop cycle; 0 in IDLE.
//  - Config/baud_div changes mid-frame ignored until next frame start; en=0 mid-frame finishes frame.
//  - Never pops when fifo_empty=1; at most one pop per frame.
// STRUCTURE
//  - uart_pkg: typedef enum uart_tx_state_t {IDLE,START,DATA,PARITY,STOP}; struct uart_cfg_t
//    {parity_en, parity_odd, stop2}; shared with future uart_rx.
//  - Sub-module uart_baud_gen: loadable down-counter, DIV_WIDTH, emits bit_end pulse; reused by uart_rx.
//  - Top: FSM, shift register, bit counter, parity accumulator, registered txd.
// TESTING
//  1 Reset: hold rst_n=0 -> txd=1, fifo_pop=0, busy=0, tx_done=0; assert mid-DATA -> txd=1 at once.
//  2 0xA5, baud_div=3, no parity, stop2=0 -> one pop; txd 0,1,0,1,0,0,1,0,1,1 each 4 clk; tx_done at clk 40.
//  3 0x07, parity_en=1: parity_odd=0 -> parity bit 1; parity_odd=1 -> 0; 11-bit frame.
//  4 FIFO {0x00,0xFF}, stop2=1, baud_div=0 -> exactly 2 pops, 2nd start bit directly after 2nd stop, 22 clk.
//  5 en=1 with fifo_empty=1 for 100 clk -> no pop, txd=1; en=0 with data -> no pop; drop en mid-frame -> frame completes.
//  6 Change baud_div 3->7 mid-frame -> current frame stays 4 clk/bit, next frame 8 clk/bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state encoding and per-frame line configuration.
package uart_pkg;

  localparam int unsigned UART_STATE_W = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } uart_cfg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter; bit_end_c marks the last clock of each bit period.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_end_c
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // Load starts a new period; while running, reload on expiry; parked at 0 otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = div;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_c = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// FIFO-draining UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_pop,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [UART_STATE_W-1:0] S_IDLE   = IDLE;
  localparam logic [UART_STATE_W-1:0] S_START  = START;
  localparam logic [UART_STATE_W-1:0] S_DATA   = DATA;
  localparam logic [UART_STATE_W-1:0] S_PARITY = PARITY;
  localparam logic [UART_STATE_W-1:0] S_STOP   = STOP;

  logic [UART_STATE_W-1:0] state_q,   state_d;
  logic [WIDTH-1:0]        shift_q,   shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    parity_q,  parity_d;
  uart_cfg_t               cfg_q,     cfg_d;
  logic [DIV_WIDTH-1:0]    div_q,     div_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    txd_q,     txd_d;
  logic                    busy_q,    busy_d;

  logic                    pop_c;
  logic                    done_c;
  logic                    start_ok_c;
  logic                    bit_end_c;
  logic                    baud_run_c;
  logic [DIV_WIDTH-1:0]    baud_sel_c;

  assign start_ok_c = en && !fifo_empty;
  assign baud_run_c = (state_q != S_IDLE);
  assign baud_sel_c = pop_c ? baud_div : div_q;

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (baud_run_c),
    .load     (pop_c),
    .div      (baud_sel_c),
    .bit_end_c(bit_end_c)
  );

  // Next-state, datapath and strobe decode; txd_d is the line level for the next cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    cfg_d      = cfg_q;
    div_d      = div_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    pop_c      = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (start_ok_c) begin
          pop_c = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
          parity_d  = parity_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            if (cfg_q.parity_en) begin
              state_d = S_PARITY;
              txd_d   = parity_q ^ cfg_q.parity_odd;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            txd_d     = shift_q[0];
            parity_d  = parity_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (cfg_q.stop2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_c  = 1'b1;
            state_d = S_IDLE;
            txd_d   = 1'b1;
            if (start_ok_c) begin
              pop_c = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame launch: capture word and line config together with the pop.
    if (pop_c) begin
      state_d         = S_START;
      txd_d           = 1'b0;
      shift_d         = fifo_rdata;
      parity_d        = 1'b0;
      stop_cnt_d      = 1'b0;
      div_d           = baud_div;
      cfg_d.parity_en  = parity_en;
      cfg_d.parity_odd = parity_odd;
      cfg_d.stop2      = stop2;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State and datapath registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      cfg_q      <= '0;
      div_q      <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      cfg_q      <= cfg_d;
      div_q      <= div_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_pop = pop_c;
  assign tx_done  = done_c;
  assign txd      = txd_q;
  assign busy     = busy_q;

endmodule
